// File: rtl/scope_ctrl_pkg.sv
// Shared types and constants for the scope acquisition sequencer.
// Holds the FSM state encoding, acquisition modes and cfg_data field positions.
package scope_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StWaitEn  = 3'd2,
    StPrefill = 3'd3,
    StWaitTrg = 3'd4,
    StPost    = 3'd5,
    StDone    = 3'd6
  } state_e;

  localparam logic [1:0] ModeNormal = 2'd0;
  localparam logic [1:0] ModeAuto   = 2'd1;
  localparam logic [1:0] ModeSingle = 2'd2;

  localparam int unsigned CfgStartBit = 0;
  localparam int unsigned CfgStopBit  = 1;
  localparam int unsigned CfgModeLsb  = 2;
  localparam int unsigned CfgEdgeBit  = 4;
  localparam int unsigned CfgChanBit  = 5;
  localparam int unsigned CfgHystLsb  = 16;

endpackage

// File: rtl/scope_edge_detect.sv
// Level/edge trigger detector with hysteresis on one signed 16-bit channel.
// hit_o is combinational from the current sample; the caller registers it.
module scope_edge_detect
  import scope_ctrl_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXIS_TDATA_WIDTH-1:0] sample_i,
  input  logic                        valid_i,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic                        edge_fall_i,
  input  logic                        chan_sel_i,
  input  logic [15:0]                 hyst_i,
  input  logic [15:0]                 level_i,
  output logic                        hit_o
);

  logic [15:0]        chan;
  logic signed [17:0] smp, lvl, hyst, lo_thr, hi_thr;
  logic               arm_cond, fire_cond, fire;
  logic               primed_q, primed_d;

  always_comb begin
    chan      = chan_sel_i ? sample_i[AXIS_TDATA_WIDTH-1 -: 16] : sample_i[15:0];
    smp       = {{2{chan[15]}}, chan};
    lvl       = {{2{level_i[15]}}, level_i};
    hyst      = {2'b00, hyst_i};
    lo_thr    = lvl - hyst;
    hi_thr    = lvl + hyst;
    arm_cond  = edge_fall_i ? (smp > hi_thr) : (smp < lo_thr);
    fire_cond = edge_fall_i ? (smp <= lvl) : (smp >= lvl);
    fire      = enable_i && valid_i && primed_q && fire_cond;

    // A fire consumes the primed bit even when the caller ignores it (pre-trigger fill).
    primed_d = primed_q;
    if (clear_i) begin
      primed_d = 1'b0;
    end else if (enable_i && valid_i) begin
      if (fire) begin
        primed_d = 1'b0;
      end else if (arm_cond) begin
        primed_d = 1'b1;
      end
    end
    hit_o = fire;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/axis_scope_controller.sv
// Acquisition sequencer for the axis_oscilloscope capture core: arms, triggers and
// re-arms the core, and reports state, auto-trigger flag and frame count.
module axis_scope_controller
  import scope_ctrl_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 12,
  parameter int unsigned TOUT_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [31:0]                 cfg_data,
  input  logic [15:0]                 trg_level,
  input  logic [TOUT_WIDTH-1:0]       tout_data,
  input  logic [CNTR_WIDTH-1:0]       pre_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic [CNTR_WIDTH:0]         scope_sts,
  output logic                        run_flag,
  output logic                        trg_flag,
  output logic [31:0]                 sts_data
);

  state_e                state_q, state_d;
  logic                  start_q, start_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNTR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [TOUT_WIDTH-1:0] tout_cnt_q, tout_cnt_d;
  logic [15:0]           frame_q, frame_d;
  logic                  auto_q, auto_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  run_q, run_d;
  logic                  trg_q, trg_d;
  logic                  start, stop, en, hit;
  logic                  unused_bits;

  assign start       = cfg_data[CfgStartBit];
  assign stop        = cfg_data[CfgStopBit];
  assign en          = scope_sts[0];
  assign unused_bits = ^{scope_sts[CNTR_WIDTH:1], cfg_data[15:6]};

  scope_edge_detect #(
    .AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_edge (
    .clk_i      (aclk),
    .rst_i      (areset),
    .sample_i   (s_axis_tdata),
    .valid_i    (s_axis_tvalid),
    .enable_i   ((state_q == StPrefill) || (state_q == StWaitTrg)),
    .clear_i    (state_q == StArm),
    .edge_fall_i(cfg_data[CfgEdgeBit]),
    .chan_sel_i (cfg_data[CfgChanBit]),
    .hyst_i     (cfg_data[CfgHystLsb +: 16]),
    .level_i    (trg_level),
    .hit_o      (hit)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    mode_d      = mode_q;
    pre_cnt_d   = pre_cnt_q;
    tout_cnt_d  = tout_cnt_q;
    frame_d     = frame_q;
    auto_d      = auto_q;
    stop_pend_d = stop_pend_q;
    run_d       = 1'b0;
    trg_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !start_q) state_d = StArm;
      end
      StArm: begin
        run_d       = 1'b1;
        mode_d      = cfg_data[CfgModeLsb +: 2];
        pre_cnt_d   = pre_data;
        stop_pend_d = 1'b0;
        state_d     = StWaitEn;
      end
      StWaitEn: begin
        if (en) state_d = StPrefill;
      end
      StPrefill: begin
        if (!en) begin
          state_d = StIdle;
        end else if (s_axis_tvalid) begin
          if (pre_cnt_q == '0) begin
            tout_cnt_d = '0;
            state_d    = StWaitTrg;
          end else begin
            pre_cnt_d = pre_cnt_q - CNTR_WIDTH'(1);
          end
        end
      end
      StWaitTrg: begin
        if (!en) begin
          state_d = StIdle;
        end else if (s_axis_tvalid) begin
          // A real trigger wins over a coincident timeout.
          if (hit) begin
            trg_d   = 1'b1;
            auto_d  = 1'b0;
            state_d = StPost;
          end else if ((mode_q == ModeAuto) && (tout_cnt_q == tout_data)) begin
            trg_d   = 1'b1;
            auto_d  = 1'b1;
            state_d = StPost;
          end else begin
            tout_cnt_d = tout_cnt_q + TOUT_WIDTH'(1);
          end
        end
      end
      StPost: begin
        if (stop) stop_pend_d = 1'b1;
        if (!en) begin
          frame_d = frame_q + 16'd1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = (stop_pend_q || (mode_q == ModeSingle)) ? StIdle : StArm;
      end
      default: state_d = StIdle;
    endcase

    // Stop aborts immediately everywhere except POST, where the frame is allowed to finish.
    if (stop && (state_q != StPost)) begin
      state_d = StIdle;
      run_d   = 1'b0;
      trg_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      mode_q      <= ModeNormal;
      pre_cnt_q   <= '0;
      tout_cnt_q  <= '0;
      frame_q     <= '0;
      auto_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      run_q       <= 1'b0;
      trg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      mode_q      <= mode_d;
      pre_cnt_q   <= pre_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
      frame_q     <= frame_d;
      auto_q      <= auto_d;
      stop_pend_q <= stop_pend_d;
      run_q       <= run_d;
      trg_q       <= trg_d;
    end
  end

  assign run_flag = run_q;
  assign trg_flag = trg_q;
  assign sts_data = {frame_q, 12'd0, auto_q, state_q};

endmodule

// File: tb/tb_axis_scope_controller.sv
// Directed bench for axis_scope_controller: trigger, hysteresis, auto, pre-fill,
// stop and reset scenarios with hand-computed expectations.
module tb_axis_scope_controller;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] cfg_data;
  logic [15:0] trg_level;
  logic [31:0] tout_data;
  logic [11:0] pre_data;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [12:0] scope_sts;
  logic        run_flag, trg_flag;
  logic [31:0] sts_data;

  int total = 0;
  int bad = 0;
  int run_cnt = 0;
  int trg_cnt = 0;

  axis_scope_controller dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_data     (cfg_data),
    .trg_level    (trg_level),
    .tout_data    (tout_data),
    .pre_data     (pre_data),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .scope_sts    (scope_sts),
    .run_flag     (run_flag),
    .trg_flag     (trg_flag),
    .sts_data     (sts_data)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (run_flag) run_cnt <= run_cnt + 1;
    if (trg_flag) trg_cnt <= trg_cnt + 1;
  end

  // hyst=10, channel 0
  function automatic logic [31:0] cfg(input logic start, input logic stop,
                                      input logic [1:0] mode, input logic fall);
    return {16'd10, 10'd0, 1'b0, fall, mode, stop, start};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [15:0] v);
    s_axis_tdata  = {16'h0000, v};
    s_axis_tvalid = 1'b1;
    tick();
  endtask

  task automatic arm(input logic [1:0] mode, input logic [11:0] pre);
    s_axis_tvalid = 1'b0;
    pre_data      = pre;
    cfg_data      = cfg(1'b1, 1'b0, mode, 1'b0);
    tick();
    chk("arm_state", {29'd0, sts_data[2:0]}, 32'd1);
    cfg_data = cfg(1'b0, 1'b0, mode, 1'b0);
    tick();
    chk("run_pulse", {31'd0, run_flag}, 32'd1);
    scope_sts = 13'd1;
    tick();
    chk("run_low", {31'd0, run_flag}, 32'd0);
    chk("prefill_state", {29'd0, sts_data[2:0]}, 32'd3);
  endtask

  initial begin
    areset        = 1'b1;
    cfg_data      = '0;
    trg_level     = 16'd100;
    tout_data     = '0;
    pre_data      = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    scope_sts     = '0;
    tick();
    tick();
    chk("rst_run", {31'd0, run_flag}, 32'd0);
    chk("rst_trg", {31'd0, trg_flag}, 32'd0);
    chk("rst_sts", sts_data, 32'd0);
    areset = 1'b0;
    tick();
    chk("idle_sts", sts_data, 32'd0);

    // Rising edge, single shot, pre=4 -> five pre-fill samples, then ramp.
    arm(2'd2, 12'd4);
    repeat (4) smp(16'd0);
    chk("t1_prefill_hold", {29'd0, sts_data[2:0]}, 32'd3);
    smp(16'd0);
    chk("t1_waittrg", {29'd0, sts_data[2:0]}, 32'd4);
    for (int v = -50; v <= 200; v += 5) begin
      smp(16'(v));
      chk($sformatf("t1_ramp_trg_%0d", v), {31'd0, trg_flag}, {31'd0, v == 100});
    end
    s_axis_tvalid = 1'b0;
    chk("t1_post", {29'd0, sts_data[2:0]}, 32'd5);
    chk("t1_trg_cnt", trg_cnt, 32'd1);
    chk("t1_run_cnt", run_cnt, 32'd1);
    scope_sts = 13'd0;
    tick();
    chk("t1_done", sts_data, 32'h0001_0006);
    tick();
    chk("t1_idle", sts_data, 32'h0001_0000);

    // Hysteresis: 95/105 never primes; 89 primes, 100 fires. pre=0 -> one sample.
    arm(2'd2, 12'd0);
    smp(16'd95);
    chk("t2_pre0_waittrg", {29'd0, sts_data[2:0]}, 32'd4);
    for (int i = 0; i < 6; i++) begin
      smp(16'd95);
      smp(16'd105);
    end
    chk("t2_osc_no_trg", trg_cnt, 32'd1);
    chk("t2_osc_state", {29'd0, sts_data[2:0]}, 32'd4);
    smp(16'd89);
    chk("t2_prime_no_trg", {31'd0, trg_flag}, 32'd0);
    smp(16'd100);
    chk("t2_trg", {31'd0, trg_flag}, 32'd1);
    s_axis_tvalid = 1'b0;
    scope_sts     = 13'd0;
    tick();
    tick();
    chk("t2_idle", sts_data, 32'h0002_0000);

    // Auto mode timeout of 20 on a flat input fires on the 21st sample, then re-arms.
    tout_data = 32'd20;
    arm(2'd1, 12'd0);
    smp(16'd0);
    for (int i = 0; i <= 20; i++) begin
      smp(16'd0);
      chk($sformatf("t3_auto_trg_%0d", i), {31'd0, trg_flag}, {31'd0, i == 20});
    end
    s_axis_tvalid = 1'b0;
    chk("t3_auto_post", {28'd0, sts_data[3:0]}, 32'hD);
    scope_sts = 13'd0;
    tick();
    tick();
    tick();
    chk("t3_rearm_run", {31'd0, run_flag}, 32'd1);
    chk("t3_rearm_state", {29'd0, sts_data[2:0]}, 32'd2);
    cfg_data = cfg(1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    chk("t3_stop_idle", sts_data, 32'h0003_0008);
    chk("t3_run_cnt", run_cnt, 32'd4);

    // Crossing during pre-fill is swallowed; only a fresh crossing afterwards fires.
    arm(2'd2, 12'd8);
    smp(16'd0);
    smp(16'd50);
    smp(16'd80);
    smp(16'd150);
    chk("t4_prefill_cross", {31'd0, trg_flag}, 32'd0);
    repeat (4) smp(16'd150);
    chk("t4_prefill_hold", {29'd0, sts_data[2:0]}, 32'd3);
    smp(16'd150);
    chk("t4_waittrg", {29'd0, sts_data[2:0]}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      smp(16'd150);
      chk($sformatf("t4_stale_%0d", i), {31'd0, trg_flag}, 32'd0);
    end
    smp(16'd80);
    chk("t4_reprime", {31'd0, trg_flag}, 32'd0);
    smp(16'd120);
    chk("t4_trg", {31'd0, trg_flag}, 32'd1);
    s_axis_tvalid = 1'b0;
    scope_sts     = 13'd0;
    tick();
    tick();
    chk("t4_idle", sts_data, 32'h0004_0000);

    // Stop in WAIT_TRG together with a firing sample: no trigger, back to IDLE.
    arm(2'd0, 12'd0);
    smp(16'd0);
    cfg_data = cfg(1'b0, 1'b1, 2'd0, 1'b0);
    smp(16'd120);
    chk("t5_stop_no_trg", {31'd0, trg_flag}, 32'd0);
    chk("t5_stop_idle", sts_data, 32'h0004_0000);
    tick();
    chk("t5_trg_cnt", trg_cnt, 32'd4);
    s_axis_tvalid = 1'b0;
    scope_sts     = 13'd0;

    // Stop in POST is deferred: frame completes, then IDLE despite continuous mode.
    arm(2'd0, 12'd0);
    smp(16'd0);
    smp(16'd120);
    chk("t6_trg", {31'd0, trg_flag}, 32'd1);
    s_axis_tvalid = 1'b0;
    cfg_data      = cfg(1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    chk("t6_post_hold", {29'd0, sts_data[2:0]}, 32'd5);
    scope_sts = 13'd0;
    tick();
    chk("t6_done", sts_data, 32'h0005_0006);
    tick();
    chk("t6_idle", sts_data, 32'h0005_0000);
    tick();
    chk("t6_no_rearm", run_cnt, 32'd7);

    // Asynchronous reset in POST clears outputs without waiting for a clock edge.
    arm(2'd0, 12'd0);
    smp(16'd0);
    smp(16'd120);
    chk("t7_trg", {31'd0, trg_flag}, 32'd1);
    s_axis_tvalid = 1'b0;
    cfg_data      = '0;
    #2;
    areset = 1'b1;
    #1;
    chk("t7_rst_trg", {31'd0, trg_flag}, 32'd0);
    chk("t7_rst_run", {31'd0, run_flag}, 32'd0);
    chk("t7_rst_sts", sts_data, 32'd0);
    #3;
    areset    = 1'b0;
    scope_sts = 13'd0;
    tick();
    chk("t7_after_rst", sts_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
